mem_bus_arbiter: RTL
====================

# mem_bus_arbiter

Shares the single data-side memory port (ADDR/BURST/REQ/WRB/WDATA/RDATA/ACK/STALL/BSTROBE) between NUM_REQ bus masters: DTLB page-table walker (index 0), dcache refill/writeback router (index 1), peripheral/uncached path (index 2). It replaces the combinational TLB-over-cache OR-mux with a registered grant held for the whole transaction, so a burst is never interleaved with another master's beats. It sits between the requesters and the memory controller inside the data-memory hierarchy.

## Interface
- NUM_REQ, 3, number of requesters (2..4)
- BURST_LEN, 8, beats per INCR/WRAP burst (256-bit line / 32-bit bus)
- proc_clk  in  1  processor clock; all state on rising edge
- proc_rst_n  in  1  asynchronous, active-low reset
- m_req  in  NUM_REQ  per-requester REQ, held high until its transaction ends
- m_addr  in  NUM_REQ*32  per-requester ADDR (slice i = bits 32i+31:32i)
- m_burst  in  NUM_REQ*2  per-requester BURST: 00 single, 01 INCR, 10 WRAP, 11 reserved
- m_wrb  in  NUM_REQ  per-requester write (1) / read (0)
- m_wdata  in  NUM_REQ*32  per-requester write data
- m_bstrobe  in  NUM_REQ*4  per-requester byte strobes
- m_gnt  out  NUM_REQ  one-hot grant, registered
- m_ack  out  NUM_REQ  ACK routed to granted requester only
- m_stall  out  NUM_REQ  STALL to granted requester; 1 to any non-granted requester with m_req high
- m_rdata  out  32  RDATA broadcast (valid only with own m_ack)
- ADDR, BURST, REQ, WRB, WDATA, BSTROBE  out  32/2/1/1/32/4  memory port, muxed from granted requester
- RDATA  in  32, ACK  in  1, STALL  in  1  memory port responses

## Operation
- States: IDLE, BUSY.
- IDLE: m_gnt = 0, REQ = 0. If any m_req high, picker selects winner; m_gnt loads one-hot winner, beat counter loads 0, go BUSY.
- BUSY: memory port outputs = granted requester's signals; REQ = m_req[g]. Each cycle with ACK=1 and STALL=0 counts one beat.
- Transaction end: BURST=00 after 1 beat; BURST=01/10 after BURST_LEN beats; BURST=11 treated as single. On final beat: m_gnt cleared, state IDLE.
- Abort: granted m_req drops in BUSY -> IDLE next cycle, counter cleared, no further m_ack to that requester.
- ACK in IDLE or while STALL=1 is ignored (not counted, not routed).
- Beat counter width $clog2(BURST_LEN)+1; never wraps—terminates at BURST_LEN.
- Requests from non-granted masters are never dropped; they remain pending with m_stall=1.
- Reset values: state IDLE, m_gnt 0, counter 0, REQ 0, ADDR 0, BURST 00, WRB 0, WDATA 0, BSTROBE 0, m_ack 0, m_stall = m_req (combinational), round-robin pointer 0.

## Timing
- Arbitration latency: requester raises m_req in cycle N, m_gnt and REQ high in N+1.
- One mandatory IDLE cycle after every transaction end; back-to-back grant earliest two cycles after final ACK.
- Memory outputs are combinational from m_gnt (registered) and granted inputs; no added pipeline.
- Simultaneous final ACK and new m_req from the same master: treated as a new request in the following IDLE cycle.
- Reset asserted mid-burst: all outputs to reset values immediately (asynchronous); burst abandoned.

## Configuration
- MEM_ARB_RR_EN defined: round-robin; pointer advances to (winner+1) mod NUM_REQ at each grant; search starts at pointer.
- Not defined: fixed priority, lowest index wins (DTLB walker always first); pointer logic absent.

## Structure
- Package mem_arb_pkg: BURST_SINGLE/INCR/WRAP/RSVD encodings, arb_state_t enum (IDLE, BUSY), requester index constants REQ_DTLB=0, REQ_DCACHE=1, REQ_PERIPH=2.
- Sub-module arb_picker: combinational, inputs req vector and pointer, output one-hot winner; fixed/round-robin selected by MEM_ARB_RR_EN.

## Test plan
- Single read: m_req[1]=1, BURST=00, addr 0x0000_1000; ACK after 2 cycles -> REQ high N+1..ack, m_ack[1] once, m_rdata=RDATA, IDLE after.
- INCR burst with stalls: m_req[1], BURST=01, STALL high on beats 3 and 6 -> exactly 8 counted ACKs, grant held for all, m_stall[1] follows STALL.
- Contention, fixed priority (macro off): m_req[0] and m_req[1] rise same cycle -> m_gnt=001 first; after its single beat plus one IDLE, m_gnt=010.
- Contention, round-robin (MEM_ARB_RR_EN): all three requesting continuously, single beats -> grant order 0,1,2,0,1,2.
- Abort: m_req[2] drops after beat 3 of a WRAP burst -> IDLE next cycle, later ACKs not routed, m_ack all 0.
- Reset mid-burst: proc_rst_n low at beat 4 -> REQ, m_gnt, ADDR zero immediately; after release, pending m_req[0] granted one cycle after first edge.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the data-side memory port arbiter.
package mem_arb_pkg;

    localparam logic [1:0] BURST_SINGLE = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;
    localparam logic [1:0] BURST_RSVD   = 2'b11;

    localparam int REQ_DTLB   = 0;
    localparam int REQ_DCACHE = 1;
    localparam int REQ_PERIPH = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/arb_picker.sv
// Combinational winner selection; round-robin from ptr when MEM_ARB_RR_EN is
// defined, otherwise fixed priority with the lowest index winning.
module arb_picker
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
`ifdef MEM_ARB_RR_EN
    input  logic [PTR_W-1:0]   ptr,
`endif
    output logic [NUM_REQ-1:0] winner
);

`ifdef MEM_ARB_RR_EN
    // Walk the rotation backwards so the requester closest to ptr is assigned last.
    always_comb begin
        int idx;
        idx    = 0;
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (req[idx]) begin
                winner = NUM_REQ'(1) << idx;
            end
        end
    end
`else
    always_comb begin
        winner = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[k]) begin
                winner = NUM_REQ'(1) << k;
            end
        end
    end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Data-side memory port arbiter: registered one-hot grant held for a whole
// transaction. Define MEM_ARB_RR_EN for round-robin instead of fixed priority.
//
// state | meaning
// IDLE  | no grant, REQ low; picks a winner whenever any m_req is high
// BUSY  | m_gnt owns the memory port until final beat or abort
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int BURST_LEN = 8
) (
    input  logic                   proc_clk,
    input  logic                   proc_rst_n,
    input  logic [NUM_REQ-1:0]     m_req,
    input  logic [NUM_REQ*32-1:0]  m_addr,
    input  logic [NUM_REQ*2-1:0]   m_burst,
    input  logic [NUM_REQ-1:0]     m_wrb,
    input  logic [NUM_REQ*32-1:0]  m_wdata,
    input  logic [NUM_REQ*4-1:0]   m_bstrobe,
    output logic [NUM_REQ-1:0]     m_gnt,
    output logic [NUM_REQ-1:0]     m_ack,
    output logic [NUM_REQ-1:0]     m_stall,
    output logic [31:0]            m_rdata,
    output logic [31:0]            ADDR,
    output logic [1:0]             BURST,
    output logic                   REQ,
    output logic                   WRB,
    output logic [31:0]            WDATA,
    output logic [3:0]             BSTROBE,
    input  logic [31:0]            RDATA,
    input  logic                   ACK,
    input  logic                   STALL
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;
    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t         state, state_nxt;
    logic [NUM_REQ-1:0] gnt_nxt;
    logic [NUM_REQ-1:0] winner;
    logic [CNT_W-1:0]   cnt, cnt_nxt, cnt_inc;
    logic               beat;
    logic               last_beat;
    logic               long_burst;

`ifdef MEM_ARB_RR_EN
    logic [PTR_W-1:0]   ptr, ptr_nxt, win_idx;

    arb_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (m_req),
        .ptr    (ptr),
        .winner (winner)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner[i]) begin
                win_idx = PTR_W'(i);
            end
        end
        ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end

    always_ff @(posedge proc_clk or negedge proc_rst_n) begin
        if (!proc_rst_n) begin
            ptr <= '0;
        end else if (state == IDLE && |m_req) begin
            ptr <= ptr_nxt;
        end
    end
`else
    arb_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_picker (
        .req    (m_req),
        .winner (winner)
    );
`endif

    // Grant is one-hot (or zero), so AND-OR muxing yields zeros when idle.
    always_comb begin
        ADDR    = '0;
        BURST   = '0;
        WRB     = 1'b0;
        WDATA   = '0;
        BSTROBE = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (m_gnt[i]) begin
                ADDR    = ADDR    | m_addr[32*i +: 32];
                BURST   = BURST   | m_burst[2*i +: 2];
                WRB     = WRB     | m_wrb[i];
                WDATA   = WDATA   | m_wdata[32*i +: 32];
                BSTROBE = BSTROBE | m_bstrobe[4*i +: 4];
            end
        end
    end

    assign REQ     = |(m_req & m_gnt);
    assign m_rdata = RDATA;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            m_stall[i] = m_gnt[i] ? STALL : m_req[i];
        end
    end

    // REQ in the beat term keeps ACKs away from a requester that has aborted.
    assign beat       = (state == BUSY) && REQ && ACK && !STALL;
    assign m_ack      = beat ? m_gnt : '0;
    assign long_burst = (BURST == BURST_INCR) || (BURST == BURST_WRAP);
    assign cnt_inc    = cnt + CNT_W'(1);
    assign last_beat  = long_burst ? (cnt_inc == CNT_W'(BURST_LEN)) : 1'b1;

    always_comb begin
        state_nxt = state;
        gnt_nxt   = m_gnt;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (|m_req) begin
                    state_nxt = BUSY;
                    gnt_nxt   = winner;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (!REQ || (beat && last_beat)) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (beat) begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge proc_clk or negedge proc_rst_n) begin
        if (!proc_rst_n) begin
            state <= IDLE;
            m_gnt <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            m_gnt <= gnt_nxt;
            cnt   <= cnt_nxt;
        end
    end

endmodule
